// File: rtl/bcd2bin_16.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// One shift/adjust iteration per clock, BW iterations per conversion.
module bcd2bin_16 #(
  parameter int NDIG = 4,
  parameter int BW   = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [BW-1:0]     bin_out,
  output logic              rdy,
  output logic              busy,
  output logic              err
);

  localparam int SW = 4*NDIG + BW;
  localparam int CW = $clog2(BW+1);
  localparam logic [CW-1:0] LAST = CW'(BW-1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [SW-1:0]   sr_sh, sr_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic            err_q, err_d;
  logic            bad_q, bad_d;
  logic            digit_bad;
  logic [3:0]      nib;

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  // Shift first, then fix up every upper-field nibble that landed >= 8.
  always_comb begin
    sr_sh  = sr_q >> 1;
    sr_adj = sr_sh;
    nib    = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      nib = sr_sh[BW + 4*i +: 4];
      if (nib >= 4'd8) sr_adj[BW + 4*i +: 4] = nib - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    bad_d   = bad_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (en) begin
          state_d = SHIFT;
          err_d   = 1'b0;
          bad_d   = digit_bad;
          // Bad input takes a single pass through SHIFT.
          if (digit_bad) begin
            sr_d  = '0;
            cnt_d = LAST;
          end else begin
            sr_d  = {bcd_in, {BW{1'b0}}};
            cnt_d = '0;
          end
        end
      end
      SHIFT: begin
        sr_d  = sr_adj;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          bin_d   = bad_q ? '0 : sr_adj[BW-1:0];
          err_d   = bad_q;
          bad_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
      if (state_q == SHIFT && cnt_q == LAST && !bad_q)
        assert (sr_adj[SW-1:BW] == '0);
    end
  end

  assign bin_out = bin_q;
  assign err     = err_q;
  assign rdy     = (state_q == DONE);
  assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_bcd2bin_16.sv
// Directed scoreboard bench for bcd2bin_16.
// Expected values come from a decimal model of the BCD input.
module tb_bcd2bin_16;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] bcd_in;
  logic [13:0] bin_out;
  logic        rdy;
  logic        busy;
  logic        err;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [14:0] sb[$];
  logic [13:0] last_bin;

  bcd2bin_16 dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .bcd_in (bcd_in),
    .bin_out(bin_out),
    .rdy    (rdy),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] model(input logic [15:0] b);
    logic bad;
    int   v;
    bad = 1'b0;
    v   = 0;
    for (int i = 3; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    if (bad) return {1'b1, 14'd0};
    return {1'b0, 14'(v)};
  endfunction

  task automatic start(input logic [15:0] b, input bit push);
    en     = 1'b1;
    bcd_in = b;
    if (push) sb.push_back(model(b));
    step();
    en = 1'b0;
    chk("rdy_drop", {31'b0, rdy}, 32'd0);
    chk("busy_on", {31'b0, busy}, 32'd1);
    chk("hold_bin", {18'b0, bin_out}, {18'b0, last_bin});
  endtask

  task automatic wait_res(input string tag, input int lat, input int pre);
    int          cyc;
    bit          bb;
    bit          bh;
    logic [14:0] e;
    cyc = pre;
    bb  = 1'b0;
    bh  = 1'b0;
    while (rdy !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) bb = 1'b1;
      if (bin_out !== last_bin) bh = 1'b1;
      step();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_busy"}, {31'b0, bb}, 32'd0);
    chk({tag, "_hold"}, {31'b0, bh}, 32'd0);
    chk({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_bin"}, {18'b0, bin_out}, {18'b0, e[13:0]});
      chk({tag, "_err"}, {31'b0, err}, {31'b0, e[14]});
      last_bin = e[13:0];
    end
  endtask

  initial begin
    bit hb;
    reset    = 1'b1;
    en       = 1'b0;
    bcd_in   = 16'h0;
    last_bin = 14'd0;
    repeat (2) step();
    chk("rst_rdy", {31'b0, rdy}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_bin", {18'b0, bin_out}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b0;
    step();

    start(16'h0000, 1'b1);
    wait_res("zero", 14, 0);

    start(16'h0001, 1'b1);
    wait_res("one", 14, 0);
    start(16'h0189, 1'b1);
    wait_res("d189", 14, 0);
    start(16'h4095, 1'b1);
    wait_res("d4095", 14, 0);
    start(16'h9999, 1'b1);
    wait_res("d9999", 14, 0);

    start(16'h00A5, 1'b1);
    wait_res("bad", 1, 0);
    start(16'h0010, 1'b1);
    wait_res("ten", 14, 0);

    start(16'h1234, 1'b1);
    repeat (4) step();
    en     = 1'b1;
    bcd_in = 16'h0777;
    step();
    en     = 1'b0;
    bcd_in = 16'h3333;
    wait_res("ignore", 14, 5);

    start(16'h5678, 1'b0);
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_rdy", {31'b0, rdy}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_bin", {18'b0, bin_out}, 32'd0);
    chk("abort_err", {31'b0, err}, 32'd0);
    last_bin = 14'd0;

    start(16'h0042, 1'b1);
    wait_res("d42", 14, 0);

    hb = 1'b0;
    repeat (20) begin
      step();
      if (rdy !== 1'b1 || err !== 1'b0 || bin_out !== last_bin) hb = 1'b1;
    end
    chk("done_hold", {31'b0, hb}, 32'd0);
    chk("done_bin", {18'b0, bin_out}, 32'd42);
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
